sb_tx_arbiter: RTL and testbench
================================

Name: sb_tx_arbiter

Overview:
- Shares the single sideband transmit serializer of the logical layer between three requesters: link-training transaction generator (LT), AT response generator (ATR) and AT command generator (ATC).
- Enforces a minimum idle gap between transactions on SBTX.
- Allows only one outstanding AT command and times out a missing AT response.
- Sits between the LT/AT sources and the SBTX serializer in the sb_clk domain.

Parameters:
- DATA_W, 64, width of one sideband transaction descriptor.
- IDLE_GAP, 2, minimum sb_clk cycles of idle between ser_done and the next grant (0 allowed).
- RSP_TIMEOUT, 1000, sb_clk cycles an AT command may wait for its response (>=2).

Ports:
- sb_clk  in  1  sideband clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- lane_disable  in  1  1 blocks new grants; a transaction already in flight completes.
- lt_req_valid / atr_req_valid / atc_req_valid  in  1 each  request valid; held until ready.
- lt_req_data / atr_req_data / atc_req_data  in  DATA_W each  descriptor.
- lt_req_ready / atr_req_ready / atc_req_ready  out  1 each  handshake accept.
- ser_start  out  1  one-cycle start pulse to the serializer.
- ser_data  out  DATA_W  latched descriptor; stable from ser_start until ser_done.
- ser_src  out  2  source of the current transaction: 0=LT, 1=ATR, 2=ATC.
- ser_done  in  1  serializer finished the last bit.
- at_rsp_rcvd  in  1  pulse: AT response decoded on SBRX.
- at_outstanding  out  1  an AT command has been sent and awaits its response.
- at_timeout  out  1  one-cycle pulse when RSP_TIMEOUT expires.

Behaviour:
- Reset values: all outputs 0; state IDLE; timers 0; arb_en_q 0.
- arb_en_q sets to 1 on the first sb_clk edge after reset release, so ready stays 0 during reset and on that first cycle.
- States:
  - IDLE: grant when arb_en_q & ~lane_disable and at least one eligible valid exists.
  - SEND: wait for ser_done.
  - GAP: count down.
- Eligibility:
  - LT and ATR are always eligible.
  - ATC is eligible only if at_outstanding=0 and no ATC transaction is in SEND/GAP awaiting set.
- Priority: LT > ATR > ATC, fixed.
- Handshake:
  - ready_x is combinational, equal to (state==IDLE) & enable & winner==x.
  - Handshake occurs in cycle N when valid & ready are both high. At most one ready is high per cycle.
  - Edge N→N+1: latch data into ser_data, set ser_src, state→SEND, ser_start=1 during cycle N+1 only.
- SEND: ser_done → GAP with counter=IDLE_GAP, or directly → IDLE if IDLE_GAP=0. ser_done in any other state is ignored.
- GAP: decrement each cycle; at 0 → IDLE. Next grant is possible IDLE_GAP+1 cycles after ser_done.
- lane_disable asserted in SEND/GAP: the current sequence completes; no grant while it is high.
- AT tracker:
  - ser_done with ser_src=2 sets at_outstanding and clears the timer.
  - While outstanding, the timer increments each cycle.
  - When timer==RSP_TIMEOUT-1: at_timeout pulses for 1 cycle and at_outstanding clears.
  - at_rsp_rcvd while outstanding: clears at_outstanding; no timeout pulse, including when it coincides with expiry.
  - at_rsp_rcvd while not outstanding: ignored.
- Timer width is clog2(RSP_TIMEOUT+1); it saturates (never wraps).

Optional Feature:
- SB_TX_ARB_RR_EN defined: LT keeps top priority; ATR and ATC use round-robin. A 1-bit pointer toggles to favour the other source after each ATR or ATC grant. The pointer resets to favour ATR.
- Undefined: fixed priority LT > ATR > ATC as above.

Decomposition:
- Package sb_arb_pkg:
  - state enum {IDLE, SEND, GAP}.
  - Source encodings SRC_LT=2'd0, SRC_ATR=2'd1, SRC_ATC=2'd2.
- Sub-module sb_rsp_timer: outstanding flag plus timeout counter; inputs are set / clear / sb_clk / rst.

Test Plan:
- Reset release with all three valids high → no ready in the first cycle; cycle 2 lt_req_ready=1; ser_start next cycle with ser_src=0.
- ATR and ATC both valid, IDLE_GAP=2, ser_done at cycle T → ATR granted first; ATC ready at T+3 exactly.
- ATC sent, no response, RSP_TIMEOUT=1000 → at_timeout pulses 1000 cycles after ser_done; second ATC is blocked until then, then granted.
- at_rsp_rcvd on the same cycle the timer hits 999 → at_outstanding clears, at_timeout stays 0.
- lane_disable=1 raised mid-SEND → the transaction completes; no ready while high; grant the cycle after GAP ends once lane_disable=0.
- SB_TX_ARB_RR_EN, ATR and ATC continuously valid with responses returned → grants alternate ATR, ATC, ATR, …; an LT valid preempts at the next IDLE.

Source files
------------

// File: rtl/sb_arb_pkg.sv
// Shared types for the sideband TX arbiter: FSM states and source encodings.
package sb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SRC_LT  = 2'd0;
  localparam logic [1:0] SRC_ATR = 2'd1;
  localparam logic [1:0] SRC_ATC = 2'd2;

endpackage

// File: rtl/sb_rsp_timer.sv
// AT response tracker: outstanding flag plus a saturating wait counter that
// raises a one-cycle timeout pulse unless the response arrives first.
module sb_rsp_timer #(
  parameter int unsigned RSP_TIMEOUT = 1000
) (
  input  logic sb_clk,
  input  logic rst,
  input  logic set_i,
  input  logic clear_i,
  output logic outstanding_o,
  output logic timeout_o
);

  localparam int unsigned   TW     = $clog2(RSP_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(RSP_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(RSP_TIMEOUT);

  logic          out_q, out_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          expire;

  always_comb begin
    expire    = out_q && (tmr_q == T_LAST);
    timeout_o = expire && !clear_i;
    out_d     = out_q;
    tmr_d     = tmr_q;
    if (out_q && (tmr_q != T_MAX)) tmr_d = tmr_q + 1'b1;
    // A response on the expiry cycle wins: the flag clears without a pulse.
    if (out_q && (clear_i || expire)) out_d = 1'b0;
    if (set_i) begin
      out_d = 1'b1;
      tmr_d = '0;
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      out_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      out_q <= out_d;
      tmr_q <= tmr_d;
    end
  end

  assign outstanding_o = out_q;

endmodule

// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: LT/ATR/ATC share one serializer with an idle gap.
// Define SB_TX_ARB_RR_EN for round-robin between ATR and ATC (LT stays first).
module sb_tx_arbiter
  import sb_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned IDLE_GAP    = 2,
  parameter int unsigned RSP_TIMEOUT = 1000
) (
  input  logic              sb_clk,
  input  logic              rst,
  input  logic              lane_disable,
  input  logic              lt_req_valid,
  input  logic [DATA_W-1:0] lt_req_data,
  output logic              lt_req_ready,
  input  logic              atr_req_valid,
  input  logic [DATA_W-1:0] atr_req_data,
  output logic              atr_req_ready,
  input  logic              atc_req_valid,
  input  logic [DATA_W-1:0] atc_req_data,
  output logic              atc_req_ready,
  output logic              ser_start,
  output logic [DATA_W-1:0] ser_data,
  output logic [1:0]        ser_src,
  input  logic              ser_done,
  input  logic              at_rsp_rcvd,
  output logic              at_outstanding,
  output logic              at_timeout
);

  localparam int unsigned   GW       = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;
  logic              arb_en_q;
  logic              start_q;
  logic              atc_elig;
  logic              win_vld;
  logic [1:0]        win;
  logic [DATA_W-1:0] win_data;
  logic              grant;
  logic              at_set;
`ifdef SB_TX_ARB_RR_EN
  logic              rr_q, rr_d;
`endif

  always_comb begin
    atc_elig = !at_outstanding && !((state_q != IDLE) && (src_q == SRC_ATC));
    win_vld  = 1'b1;
    win      = SRC_LT;
    if (lt_req_valid) win = SRC_LT;
`ifdef SB_TX_ARB_RR_EN
    else if (atr_req_valid && atc_req_valid && atc_elig) win = rr_q ? SRC_ATC : SRC_ATR;
`endif
    else if (atr_req_valid) win = SRC_ATR;
    else if (atc_req_valid && atc_elig) win = SRC_ATC;
    else win_vld = 1'b0;

    case (win)
      SRC_ATR: win_data = atr_req_data;
      SRC_ATC: win_data = atc_req_data;
      default: win_data = lt_req_data;
    endcase
  end

  // The winner is chosen only among valid requesters, so a grant is a handshake.
  assign grant         = (state_q == IDLE) && arb_en_q && !lane_disable && win_vld;
  assign lt_req_ready  = grant && (win == SRC_LT);
  assign atr_req_ready = grant && (win == SRC_ATR);
  assign atc_req_ready = grant && (win == SRC_ATC);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    src_d   = src_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = SEND;
          data_d  = win_data;
          src_d   = win;
        end
      end
      SEND: begin
        if (ser_done) begin
          if (IDLE_GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SB_TX_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (grant && (win == SRC_ATR)) rr_d = 1'b1;
    if (grant && (win == SRC_ATC)) rr_d = 1'b0;
  end
`endif

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      data_q   <= '0;
      src_q    <= SRC_LT;
      arb_en_q <= 1'b0;
      start_q  <= 1'b0;
`ifdef SB_TX_ARB_RR_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      src_q    <= src_d;
      arb_en_q <= 1'b1;
      start_q  <= grant;
`ifdef SB_TX_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign at_set = (state_q == SEND) && ser_done && (src_q == SRC_ATC);

  sb_rsp_timer #(
    .RSP_TIMEOUT(RSP_TIMEOUT)
  ) u_rsp_timer (
    .sb_clk       (sb_clk),
    .rst          (rst),
    .set_i        (at_set),
    .clear_i      (at_rsp_rcvd),
    .outstanding_o(at_outstanding),
    .timeout_o    (at_timeout)
  );

  assign ser_start = start_q;
  assign ser_data  = data_q;
  assign ser_src   = src_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter with a cycle-level reference model.
module tb_sb_tx_arbiter;

  localparam int DATA_W      = 64;
  localparam int IDLE_GAP    = 2;
  localparam int RSP_TIMEOUT = 1000;
`ifdef SB_TX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              sb_clk = 1'b0;
  logic              rst = 1'b0;
  logic              lane_disable = 1'b0;
  logic              lt_req_valid = 1'b0, atr_req_valid = 1'b0, atc_req_valid = 1'b0;
  logic [DATA_W-1:0] lt_req_data = '0, atr_req_data = '0, atc_req_data = '0;
  logic              lt_req_ready, atr_req_ready, atc_req_ready;
  logic              ser_start;
  logic [DATA_W-1:0] ser_data;
  logic [1:0]        ser_src;
  logic              ser_done = 1'b0;
  logic              at_rsp_rcvd = 1'b0;
  logic              at_outstanding, at_timeout;

  sb_tx_arbiter #(
    .DATA_W(DATA_W), .IDLE_GAP(IDLE_GAP), .RSP_TIMEOUT(RSP_TIMEOUT)
  ) dut (
    .sb_clk(sb_clk), .rst(rst), .lane_disable(lane_disable),
    .lt_req_valid(lt_req_valid), .lt_req_data(lt_req_data), .lt_req_ready(lt_req_ready),
    .atr_req_valid(atr_req_valid), .atr_req_data(atr_req_data), .atr_req_ready(atr_req_ready),
    .atc_req_valid(atc_req_valid), .atc_req_data(atc_req_data), .atc_req_ready(atc_req_ready),
    .ser_start(ser_start), .ser_data(ser_data), .ser_src(ser_src), .ser_done(ser_done),
    .at_rsp_rcvd(at_rsp_rcvd), .at_outstanding(at_outstanding), .at_timeout(at_timeout)
  );

  always #5 sb_clk = ~sb_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: busy/free-time bookkeeping and an AT response deadline.
  bit                m_en, m_sending, m_out, m_fav_atc;
  int                m_free_at, m_start_at, m_deadline;
  logic [1:0]        m_src;
  logic [DATA_W-1:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit idle, atc_ok, set_now;
    int win;
    cyc++;
    if (!rst) begin
      m_en = 0; m_sending = 0; m_out = 0; m_fav_atc = 0;
      m_free_at = 0; m_start_at = -1; m_deadline = 0;
      m_src = 2'd0; m_data = '0;
    end
    idle   = rst && m_en && !m_sending && (cyc >= m_free_at) && !lane_disable;
    atc_ok = !m_out && !(m_sending && m_src == 2'd2);
    win    = -1;
    if (idle) begin
      if (lt_req_valid) win = 0;
      else if (atr_req_valid && atc_req_valid && atc_ok) win = (RR && m_fav_atc) ? 2 : 1;
      else if (atr_req_valid) win = 1;
      else if (atc_req_valid && atc_ok) win = 2;
    end
    check("lt_ready",  64'(lt_req_ready),  64'(win == 0));
    check("atr_ready", 64'(atr_req_ready), 64'(win == 1));
    check("atc_ready", 64'(atc_req_ready), 64'(win == 2));
    check("ser_start", 64'(ser_start), 64'(cyc == m_start_at));
    check("ser_src",   64'(ser_src),   64'(m_src));
    check("ser_data",  64'(ser_data),  64'(m_data));
    check("at_outstanding", 64'(at_outstanding), 64'(m_out));
    check("at_timeout", 64'(at_timeout), 64'(m_out && cyc == m_deadline && !at_rsp_rcvd));
    if (rst) begin
      set_now = 0;
      if (m_sending && ser_done) begin
        m_sending = 0;
        m_free_at = cyc + IDLE_GAP + 1;
        set_now   = (m_src == 2'd2);
      end
      if (m_out && (at_rsp_rcvd || cyc == m_deadline)) m_out = 0;
      if (set_now) begin
        m_out = 1;
        m_deadline = cyc + RSP_TIMEOUT;
      end
      if (win >= 0) begin
        m_sending  = 1;
        m_src      = 2'(win);
        m_data     = (win == 0) ? lt_req_data : (win == 1) ? atr_req_data : atc_req_data;
        m_start_at = cyc + 1;
        if (win == 1) m_fav_atc = 1;
        if (win == 2) m_fav_atc = 0;
      end
      m_en = 1;
    end
  endtask

  // Every cycle passes through the model comparison; stimulus resumes 1 after posedge.
  task automatic tick();
    @(negedge sb_clk);
    model_step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic send_one(input string tag, output logic [1:0] s);
    int n = 0;
    #1;
    while (!(lt_req_ready || atr_req_ready || atc_req_ready) && n < 50) begin
      tick(); #1; n++;
    end
    check({tag, "_grant_bound"}, 64'(n < 50), 64'd1);
    tick(); #1;
    s = ser_src;
    check({tag, "_start"}, 64'(ser_start), 64'd1);
    if (s == 2'd0) lt_req_valid = 1'b0;
    $display("grant %s src=%0d data=%0h cycle %0d", tag, s, ser_data, cyc);
    tick();
    ser_done = 1'b1; tick(); ser_done = 1'b0;
    if (s == 2'd2) begin
      at_rsp_rcvd = 1'b1; tick(); at_rsp_rcvd = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [1:0] s;
    int exp_seq [4];
    lt_req_data  = 64'h1111_0000_0000_0001;
    atr_req_data = 64'h2222_0000_0000_0002;
    atc_req_data = 64'h3333_0000_0000_0003;
    lt_req_valid = 1'b1; atr_req_valid = 1'b1; atc_req_valid = 1'b1;
    repeat (3) tick();
    check("reset_ser_start", 64'(ser_start), 64'd0);
    check("reset_at_outstanding", 64'(at_outstanding), 64'd0);

    // Reset release: ready only from the second cycle.
    rst = 1'b1; #1;
    check("rel_c1_lt_ready", 64'(lt_req_ready), 64'd0);
    tick(); #1;
    check("rel_c2_lt_ready", 64'(lt_req_ready), 64'd1);
    check("rel_c2_atr_ready", 64'(atr_req_ready), 64'd0);
    tick(); #1;
    check("lt_start", 64'(ser_start), 64'd1);
    check("lt_src", 64'(ser_src), 64'd0);
    check("lt_data", ser_data, 64'h1111_0000_0000_0001);
    $display("txn LT src=%0d cycle %0d", ser_src, cyc);
    lt_req_valid = 1'b0;

    // ATR beats ATC; each next grant lands IDLE_GAP+1 cycles after ser_done.
    tick();
    ser_done = 1'b1; tick(); ser_done = 1'b0;
    tick(); #1;
    check("atr_ready_T2", 64'(atr_req_ready), 64'd0);
    tick(); #1;
    check("atr_ready_T3", 64'(atr_req_ready), 64'd1);
    check("atc_ready_T3", 64'(atc_req_ready), 64'd0);
    tick(); #1;
    check("atr_src", 64'(ser_src), 64'd1);
    $display("txn ATR src=%0d cycle %0d", ser_src, cyc);
    atr_req_valid = 1'b0;
    ser_done = 1'b1; tick(); ser_done = 1'b0;
    tick(); #1;
    check("atc_ready_T2", 64'(atc_req_ready), 64'd0);
    tick(); #1;
    check("atc_ready_T3", 64'(atc_req_ready), 64'd1);
    tick(); #1;
    check("atc_src", 64'(ser_src), 64'd2);
    check("atc_data", ser_data, 64'h3333_0000_0000_0003);
    $display("txn ATC src=%0d cycle %0d", ser_src, cyc);
    atc_req_valid = 1'b0;

    // No response: timeout 1000 cycles after ser_done, second ATC held off until then.
    ser_done = 1'b1; tick(); ser_done = 1'b0;
    atc_req_data = 64'h3333_0000_0000_0004;
    atc_req_valid = 1'b1; #1;
    check("atc_outstanding_set", 64'(at_outstanding), 64'd1);
    k = 1;
    while (!at_timeout && k < 1100) begin
      tick(); #1; k++;
    end
    check("timeout_latency", 64'(k), 64'd1000);
    check("atc_blocked_at_timeout", 64'(atc_req_ready), 64'd0);
    $display("txn ATC timeout after %0d cycles, cycle %0d", k, cyc);
    tick(); #1;
    check("atc2_ready", 64'(atc_req_ready), 64'd1);
    tick(); #1;
    check("atc2_data", ser_data, 64'h3333_0000_0000_0004);
    atc_req_valid = 1'b0;

    // Response on the expiry cycle suppresses the timeout pulse.
    ser_done = 1'b1; tick(); ser_done = 1'b0;
    repeat (999) tick();
    at_rsp_rcvd = 1'b1; #1;
    check("coinc_timeout", 64'(at_timeout), 64'd0);
    check("coinc_outstanding", 64'(at_outstanding), 64'd1);
    tick(); at_rsp_rcvd = 1'b0; #1;
    check("coinc_cleared", 64'(at_outstanding), 64'd0);
    $display("txn ATC response on expiry cycle %0d", cyc);
    at_rsp_rcvd = 1'b1; tick(); at_rsp_rcvd = 1'b0;

    // lane_disable raised mid-SEND: current transaction finishes, grants wait for release.
    lt_req_data = 64'h1111_0000_0000_00A0;
    lt_req_valid = 1'b1; #1;
    check("ld_first_ready", 64'(lt_req_ready), 64'd1);
    tick();
    lt_req_data = 64'h1111_0000_0000_00B0;
    lane_disable = 1'b1;
    tick();
    ser_done = 1'b1; tick(); ser_done = 1'b0;
    tick(); tick(); #1;
    check("ld_idle_blocked_T3", 64'(lt_req_ready), 64'd0);
    tick(); #1;
    check("ld_idle_blocked_T4", 64'(lt_req_ready), 64'd0);
    tick(); lane_disable = 1'b0; #1;
    check("ld_release_ready", 64'(lt_req_ready), 64'd1);
    tick(); #1;
    check("ld_second_data", ser_data, 64'h1111_0000_0000_00B0);
    $display("txn LT after lane_disable cycle %0d", cyc);
    lt_req_valid = 1'b0;
    ser_done = 1'b1; tick(); ser_done = 1'b0;

    // ATR/ATC contention with responses returned, then LT preemption.
    if (RR) exp_seq = '{1, 2, 1, 2};
    else    exp_seq = '{1, 1, 1, 1};
    atr_req_valid = 1'b1; atc_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_one("contend", s);
      check("contend_src", 64'(s), 64'(exp_seq[i]));
    end
    lt_req_valid = 1'b1;
    send_one("preempt", s);
    check("preempt_src", 64'(s), 64'd0);
    send_one("after_preempt", s);
    check("after_preempt_src", 64'(s), 64'd1);
    atr_req_valid = 1'b0; atc_req_valid = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
